// File: rtl/hazard_pkg.sv
// Shared encodings for the parametrised hazard unit: forwarding mux selects and
// the multi-cycle execute FSM state type.
package hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {HZ_IDLE = 1'b0, HZ_BUSY = 1'b1} hzState_t;
endpackage

// File: rtl/hazard_unit_param_mul_stall_fsm.sv
// Multi-cycle execute tracker: holds a MUL in E for MUL_LAT cycles, stalling the
// front of the pipe for MUL_LAT-1 of them and flagging the final cycle.
module mul_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic MulStartE,
    output logic MulStall,
    output logic MulDoneE
);
    localparam int CW = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0] LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    hzState_t state, stateNext;
    logic [CW-1:0] cnt, cntNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HZ_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        MulStall  = 1'b0;
        MulDoneE  = 1'b0;
        case (state)
            HZ_IDLE: begin
                if (MulStartE) begin
                    if (MUL_LAT > 1) begin
                        stateNext = HZ_BUSY;
                        cntNext   = LOAD;
                        MulStall  = 1'b1;
                    end else begin
                        MulDoneE  = 1'b1;
                    end
                end
            end
            HZ_BUSY: begin
                // MulStartE is still high here (MUL held in E) and is ignored
                cntNext = cnt - ONE;
                if (cnt > ONE) MulStall = 1'b1;
                if (cnt == ONE) begin
                    MulDoneE  = 1'b1;
                    stateNext = HZ_IDLE;
                end
            end
            default: stateNext = HZ_IDLE;
        endcase
        if (reset) begin
            MulStall = 1'b0;
            MulDoneE = 1'b0;
        end
    end
endmodule

// File: rtl/hazard_unit_param.sv
// Parametrised hazard unit: forwarding selects, load-use / PC-write / MUL stalls and
// flushes. Optional stall/flush statistics counters enabled by HAZARD_STATS_EN.
module hazard_unit_param
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int PC_REG     = 15,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] RA1D,
    input  logic [REG_ADDR_W-1:0] RA2D,
    input  logic [REG_ADDR_W-1:0] RA1E,
    input  logic [REG_ADDR_W-1:0] RA2E,
    input  logic [REG_ADDR_W-1:0] WA3E,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic [REG_ADDR_W-1:0] WA3W,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  MulStartE,
    input  logic                  BranchTakenE,
    input  logic                  PCSrcD,
    input  logic                  PCSrcE,
    input  logic                  PCSrcM,
    input  logic                  PCSrcW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  MulDoneE,
    output logic [CNT_W-1:0]      StallCnt,
    output logic [CNT_W-1:0]      FlushCnt
);
    localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

    logic [1:0][REG_ADDR_W-1:0] srcE;
    logic [1:0][1:0]            fwdSel;
    logic ldStall, pcWrPend, mulStall;

    assign srcE = {RA2E, RA1E};

    // One forwarding lane per E-stage source operand; M has priority over W
    for (genvar i = 0; i < 2; i++) begin : g_fwd
        logic matchM, matchW;
        assign matchM = (srcE[i] == WA3M) && (srcE[i] != PC_ADDR);
        assign matchW = (srcE[i] == WA3W) && (srcE[i] != PC_ADDR);
        always_comb begin
            fwdSel[i] = FWD_RF;
            if (reset)                     fwdSel[i] = FWD_RF;
            else if (RegWriteM && matchM)  fwdSel[i] = FWD_MEM;
            else if (RegWriteW && matchW)  fwdSel[i] = FWD_WB;
        end
    end

    assign ForwardAE = fwdSel[0];
    assign ForwardBE = fwdSel[1];

    mul_stall_fsm #(.MUL_LAT(MUL_LAT)) u_mulFsm (
        .clk       (clk),
        .reset     (reset),
        .MulStartE (MulStartE),
        .MulStall  (mulStall),
        .MulDoneE  (MulDoneE)
    );

    assign ldStall  = MemtoRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
    assign pcWrPend = PCSrcD || PCSrcE || PCSrcM;

    assign StallF = !reset && (ldStall || pcWrPend || mulStall);
    assign StallD = !reset && (ldStall || mulStall);
    assign StallE = !reset && mulStall;
    // A MUL held in E must never be squashed by a load-use bubble
    assign FlushD = reset || pcWrPend || PCSrcW || BranchTakenE;
    assign FlushE = reset || (ldStall && !mulStall) || BranchTakenE;
    assign FlushM = reset || mulStall;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && !(&StallCnt)) StallCnt <= StallCnt + CNT_W'(1);
            if (FlushE && !(&FlushCnt)) FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

    assert property (@(posedge clk) disable iff (reset) !(MulStartE && BranchTakenE));
endmodule
